// File: rtl/colour_bound_detect.sv
// colour_bound_detect
// Tracks the leftmost and rightmost x of qualified colour-match runs in a frame.
// Speckle is rejected by requiring MIN_RUN consecutive hits on one row before
// any pixel of that run counts. Results are registered and announced with a
// one-cycle eop strobe one clock after the frame's last pixel beat.
//
// Ports:
//   clk, reset_n   pixel clock, asynchronous active-low reset
//   in_valid       pixel beat qualifier; nothing advances without it
//   in_sop         first pixel of frame (forces x=0, y=0, clears accumulators)
//   in_eop         last pixel of frame (pixel evaluated, then results latched)
//   in_hit         pixel matches target colour
//   left_bound     leftmost x of qualified run in last frame (0 if none)
//   right_bound    rightmost x of qualified run in last frame (IMAGE_W-1 if none)
//   found          last frame contained at least one qualified run
//   eop            one-cycle strobe: bounds updated this cycle
module colour_bound_detect #(
    parameter int unsigned IMAGE_W   = 640,
    parameter int unsigned IMAGE_H   = 480,
    parameter int unsigned MIN_RUN   = 4,
    parameter int unsigned ROI_Y_MIN = 0,
    parameter int unsigned ROI_Y_MAX = 479
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_hit,
    output logic [10:0] left_bound,
    output logic [10:0] right_bound,
    output logic        found,
    output logic        eop
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 11;
    localparam int unsigned RW = $clog2(MIN_RUN + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMAGE_H - 1);
    localparam logic [YW-1:0] ROI_HI   = YW'(ROI_Y_MAX);
    localparam logic [RW-1:0] RUN_SAT  = RW'(MIN_RUN);
    localparam logic [XW-1:0] RUN_BACK = XW'(MIN_RUN - 1);

    logic [XW-1:0] x_q, min_l_q, max_r_q;
    logic [YW-1:0] y_q;
    logic [RW-1:0] run_q;
    logic          any_q;

    logic [XW-1:0] cur_x, x_nxt, cand_l, min_base, max_base, min_nxt, max_nxt;
    logic [YW-1:0] cur_y, y_nxt;
    logic [RW-1:0] run_base, run_nxt;
    logic          any_base, any_nxt, qual, roi_lo_ok, roi_hi_ok;

    // Lower ROI edge at row 0 is always satisfied; avoid a vacuous compare.
    generate
        if (ROI_Y_MIN == 0) begin : g_roi_lo_open
            assign roi_lo_ok = 1'b1;
        end else begin : g_roi_lo_cmp
            localparam logic [YW-1:0] ROI_LO = YW'(ROI_Y_MIN);
            assign roi_lo_ok = (cur_y >= ROI_LO);
        end
    endgenerate

    assign roi_hi_ok = (cur_y <= ROI_HI);

    // Per-beat evaluation: position, run length, qualification, accumulators.
    always_comb begin
        cur_x    = in_sop ? '0 : x_q;
        cur_y    = in_sop ? '0 : y_q;

        // x==0 starts a new row, so a run never carries across the wrap.
        run_base = (cur_x == '0) ? '0 : run_q;
        if (!in_hit)
            run_nxt = '0;
        else if (run_base == RUN_SAT)
            run_nxt = RUN_SAT;
        else
            run_nxt = run_base + RW'(1);

        qual     = (run_nxt >= RUN_SAT) && roi_lo_ok && roi_hi_ok;

        min_base = in_sop ? X_LAST : min_l_q;
        max_base = in_sop ? '0     : max_r_q;
        any_base = in_sop ? 1'b0   : any_q;

        // Leftmost pixel of the run that just reached MIN_RUN.
        cand_l   = cur_x - RUN_BACK;
        min_nxt  = (qual && (cand_l < min_base)) ? cand_l : min_base;
        max_nxt  = (qual && (cur_x > max_base))  ? cur_x  : max_base;
        any_nxt  = any_base | qual;

        if (cur_x == X_LAST) begin
            x_nxt = '0;
            y_nxt = (cur_y == Y_LAST) ? cur_y : cur_y + YW'(1);
        end else begin
            x_nxt = cur_x + XW'(1);
            y_nxt = cur_y;
        end
    end

    // Frame state; an eop beat returns everything to the reset values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            run_q   <= '0;
            min_l_q <= X_LAST;
            max_r_q <= '0;
            any_q   <= 1'b0;
        end else if (in_valid) begin
            if (in_eop) begin
                x_q     <= '0;
                y_q     <= '0;
                run_q   <= '0;
                min_l_q <= X_LAST;
                max_r_q <= '0;
                any_q   <= 1'b0;
            end else begin
                x_q     <= x_nxt;
                y_q     <= y_nxt;
                run_q   <= run_nxt;
                min_l_q <= min_nxt;
                max_r_q <= max_nxt;
                any_q   <= any_nxt;
            end
        end
    end

    // Result registers; an empty frame reports the full-width box.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_bound  <= '0;
            right_bound <= X_LAST;
            found       <= 1'b0;
            eop         <= 1'b0;
        end else begin
            eop <= in_valid && in_eop;
            if (in_valid && in_eop) begin
                found <= any_nxt;
                if (any_nxt) begin
                    left_bound  <= min_nxt;
                    right_bound <= max_nxt;
                end else begin
                    left_bound  <= '0;
                    right_bound <= X_LAST;
                end
            end
        end
    end

endmodule

// File: tb/tb_colour_bound_detect.sv
// Directed bench for colour_bound_detect: table of short frames with
// hand-computed bounds, plus hand-written abort/reset sequences.
// A second instance with a narrow ROI (rows 3..5) shares the stimulus.
module tb_colour_bound_detect;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_sop, in_eop, in_hit;
    logic [10:0] left_bound, right_bound, r_left, r_right;
    logic        found, eop, r_found, r_eop;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int exp_strobes = 0;

    always #5 clk = ~clk;

    colour_bound_detect dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_hit(in_hit), .left_bound(left_bound),
        .right_bound(right_bound), .found(found), .eop(eop)
    );

    colour_bound_detect #(.ROI_Y_MIN(3), .ROI_Y_MAX(5)) dut_roi (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_hit(in_hit), .left_bound(r_left),
        .right_bound(r_right), .found(r_found), .eop(r_eop)
    );

    always @(negedge clk) if (eop) strobe_cnt++;

    // Frame: hit rectangle A (rows a_y0..a_y1, x a_x0..a_x1) plus single-row
    // segment B; frame ends at (last_y,last_x). Expected results for both DUTs.
    typedef struct {
        int a_y0, a_y1, a_x0, a_x1;
        int b_y, b_x0, b_x1;
        int last_y, last_x;
        bit sop, do_eop, gaps, b2b;
        int f, l, r;
        int rf, rl, rr;
    } vec_t;

    function automatic vec_t mk(int a_y0, int a_y1, int a_x0, int a_x1,
                                int b_y, int b_x0, int b_x1, int last_y, int last_x,
                                bit sop, bit gaps, bit b2b,
                                int f, int l, int r, int rf, int rl, int rr);
        vec_t v;
        v.a_y0 = a_y0; v.a_y1 = a_y1; v.a_x0 = a_x0; v.a_x1 = a_x1;
        v.b_y = b_y; v.b_x0 = b_x0; v.b_x1 = b_x1;
        v.last_y = last_y; v.last_x = last_x;
        v.sop = sop; v.do_eop = 1'b1; v.gaps = gaps; v.b2b = b2b;
        v.f = f; v.l = l; v.r = r; v.rf = rf; v.rl = rl; v.rr = rr;
        return v;
    endfunction

    function automatic bit is_hit(vec_t v, int x, int y);
        return (y >= v.a_y0 && y <= v.a_y1 && x >= v.a_x0 && x <= v.a_x1) ||
               (y == v.b_y && x >= v.b_x0 && x <= v.b_x1);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(bit s, bit e, bit h, bit gaps);
        if (gaps)
            for (int k = 0; k < 4 && $urandom_range(1, 0) == 1; k++) idle();
        in_valid = 1'b1; in_sop = s; in_eop = e; in_hit = h;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_hit = 1'b0;
    endtask

    task automatic play(vec_t v);
        for (int y = 0; y <= v.last_y; y++)
            for (int x = 0; x < 640 && !(y == v.last_y && x > v.last_x); x++)
                beat(v.sop && x == 0 && y == 0,
                     v.do_eop && y == v.last_y && x == v.last_x,
                     is_hit(v, x, y), v.gaps);
        if (v.do_eop) exp_strobes++;
    endtask

    task automatic check_out(vec_t v, string tag);
        chk({tag, " eop"},       int'(eop),         1);
        chk({tag, " found"},     int'(found),       v.f);
        chk({tag, " left"},      int'(left_bound),  v.l);
        chk({tag, " right"},     int'(right_bound), v.r);
        chk({tag, " roi_eop"},   int'(r_eop),       1);
        chk({tag, " roi_found"}, int'(r_found),     v.rf);
        chk({tag, " roi_left"},  int'(r_left),      v.rl);
        chk({tag, " roi_right"}, int'(r_right),     v.rr);
    endtask

    task automatic check_after(string tag);
        idle();
        chk({tag, " eop_one_cycle"}, int'(eop), 0);
        chk({tag, " strobe_count"},  strobe_cnt, exp_strobes);
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_hit = 1'b0;

        //            A rows   A x        B row/x     last     sop gap b2b  main        roi
        vecs.push_back(mk(2, 4, 100, 139,  -1, 0, 0,    5, 639,  1, 0, 0,  1, 100, 139,  1, 100, 139));
        vecs.push_back(mk(2, 4, 100, 139,  -1, 0, 0,    5, 639,  1, 1, 0,  1, 100, 139,  1, 100, 139));
        vecs.push_back(mk(1, 3, 50, 52,    -1, 0, 0,    4, 639,  1, 0, 0,  0, 0, 639,    0, 0, 639));
        vecs.push_back(mk(4, 4, 636, 639,   5, 0, 1,    6, 10,   1, 0, 0,  1, 636, 639,  1, 636, 639));
        vecs.push_back(mk(4, 4, 637, 639,   5, 0, 1,    6, 10,   1, 0, 0,  0, 0, 639,    0, 0, 639));
        vecs.push_back(mk(1, 1, 400, 410,   7, 400, 410, 8, 0,   1, 0, 1,  1, 400, 410,  0, 0, 639));
        vecs.push_back(mk(4, 4, 400, 410,  -1, 0, 0,    4, 639,  1, 0, 0,  1, 400, 410,  1, 400, 410));
        vecs.push_back(mk(0, 0, 10, 19,    -1, 0, 0,    0, 25,   0, 0, 0,  1, 10, 19,    0, 0, 639));
        vecs.push_back(mk(0, 0, 0, 0,      -1, 0, 0,    0, 0,    1, 0, 0,  0, 0, 639,    0, 0, 639));
        vecs.push_back(mk(3, 3, 0, 3,       3, 630, 639, 3, 639, 1, 0, 0,  1, 0, 639,    1, 0, 639));

        idle(); idle();
        chk("reset left",  int'(left_bound),  0);
        chk("reset right", int'(right_bound), 639);
        chk("reset found", int'(found),       0);
        chk("reset eop",   int'(eop),         0);
        reset_n = 1'b1;
        idle();

        foreach (vecs[i]) begin
            play(vecs[i]);
            check_out(vecs[i], $sformatf("vec%0d", i));
            if (!vecs[i].b2b) check_after($sformatf("vec%0d", i));
        end

        // Mid-frame sop: the partial frame is discarded without a strobe.
        v = mk(5, 5, 20, 30, -1, 0, 0, 5, 40, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.do_eop = 1'b0;
        play(v);
        v = mk(1, 1, 300, 320, -1, 0, 0, 1, 639, 1, 0, 0, 1, 300, 320, 0, 0, 639);
        play(v);
        check_out(v, "restart");
        check_after("restart");

        // Reset mid-frame: outputs return to reset values, no strobe, and the
        // partial hits do not leak into the following frame.
        v = mk(0, 0, 5, 15, -1, 0, 0, 0, 30, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.do_eop = 1'b0;
        play(v);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset left",  int'(left_bound),  0);
        chk("midreset right", int'(right_bound), 639);
        chk("midreset found", int'(found),       0);
        chk("midreset eop",   int'(eop),         0);
        idle(); idle();
        reset_n = 1'b1;
        chk("midreset strobe_count", strobe_cnt, exp_strobes);
        v = mk(-1, -2, 0, 0, -1, 0, 0, 0, 20, 0, 0, 0, 0, 0, 639, 0, 0, 639);
        play(v);
        check_out(v, "postreset");
        check_after("postreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
